adc_responder: RTL and testbench

ADC_RESPONDER -- requirements
Module: adc_responder

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_tick_gen.sv | 31 +++
 rtl/adc_responder.sv | 116 +++++++++++
 tb/tb_adc_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the emulated ADC and the controller that drives it.
package adc_pkg;

  // Width of one ADC conversion result.
  localparam int ADC_VALUE_W = 14;

  // System clocks per emulated ADC tick (50 MHz system clock -> 2.5 MHz ADC).
  localparam int ADC_CLK_DIV_DEFAULT = 20;

  // Responder states, shared so the controller can mirror them when debugging.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_READY = 2'd1,
    ST_REQ   = 2'd2,
    ST_CONV  = 2'd3
  } adc_state_e;

endpackage : adc_pkg

// File: rtl/adc_tick_gen.sv
// Clock-enable divider: one-clk tick every CLK_DIV system clocks.
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = ADC_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_i,
  output logic tick_o
);

  localparam int                 CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free-running count 0..CLK_DIV-1, wrapping after the tick.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule : adc_tick_gen

// File: rtl/adc_responder.sv
// Emulated ADC: accepts a level request, averages 2^AVG_LOG2 samples taken
// on ADC ticks and presents the result with a ready/busy handshake.
module adc_responder
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = ADC_CLK_DIV_DEFAULT,
  parameter int MIN_REQ_TICKS = 4,
  parameter int AVG_LOG2      = 4
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   adcen,
  input  logic                   adcreqi,
  input  logic [ADC_VALUE_W-1:0] sample_i,
  output logic                   adcrdy,
  output logic [ADC_VALUE_W-1:0] adcvalue,
  output logic                   conv_done
);

  localparam int ACC_W = ADC_VALUE_W + AVG_LOG2;   // sum of 2^AVG_LOG2 samples cannot overflow
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int REQ_W = $clog2(MIN_REQ_TICKS + 1);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [REQ_W-1:0] REQ_MIN  = REQ_W'(MIN_REQ_TICKS);

  logic                   tick;
  adc_state_e             state_q, state_d;
  logic [REQ_W-1:0]       req_cnt_q, req_cnt_d;
  logic [SMP_W-1:0]       smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_sum;
  logic [ADC_VALUE_W-1:0] value_q, value_d;
  logic                   done_q, done_d;

  adc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign acc_sum = acc_q + ACC_W'(sample_i);

  // Next-state and datapath decisions; adcen low overrides everything.
  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    smp_cnt_d = smp_cnt_q;
    acc_d     = acc_q;
    value_d   = value_q;
    done_d    = 1'b0;
    if (!adcen) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (tick) state_d = ST_READY;
        end
        ST_READY: begin
          if (adcreqi) begin
            state_d   = ST_REQ;
            req_cnt_d = '0;
          end
        end
        ST_REQ: begin
          if (adcreqi) begin
            if (tick && req_cnt_q < REQ_MIN) req_cnt_d = req_cnt_q + REQ_W'(1);
          end else if (req_cnt_q >= REQ_MIN) begin
            state_d   = ST_CONV;
            acc_d     = '0;
            smp_cnt_d = '0;
          end else begin
            state_d = ST_READY;  // too short: treated as a glitch
          end
        end
        ST_CONV: begin
          if (tick) begin
            acc_d = acc_sum;
            if (smp_cnt_q == SMP_LAST) begin
              value_d = acc_sum[ACC_W-1 -: ADC_VALUE_W];
              done_d  = 1'b1;
              state_d = ST_READY;
            end else begin
              smp_cnt_d = smp_cnt_q + SMP_W'(1);
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      req_cnt_q <= '0;
      smp_cnt_q <= '0;
      acc_q     <= '0;
      value_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      acc_q     <= acc_d;
      value_q   <= value_d;
      done_q    <= done_d;
    end
  end

  assign adcrdy    = (state_q == ST_READY);
  assign adcvalue  = value_q;
  assign conv_done = done_q;

endmodule : adc_responder

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder with default parameters.
module tb_adc_responder;
  import adc_pkg::*;

  localparam int CLK_DIV = 20;
  localparam int CONV_CLKS = 16 * CLK_DIV;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   adcen = 1'b0;
  logic                   adcreqi = 1'b0;
  logic [ADC_VALUE_W-1:0] sample_i = '0;
  logic                   adcrdy;
  logic [ADC_VALUE_W-1:0] adcvalue;
  logic                   conv_done;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;   // posedges since reset release; ADC ticks land on multiples of CLK_DIV

  int clks, pulses, done_at_rdy;

  adc_responder #(.CLK_DIV(CLK_DIV), .MIN_REQ_TICKS(4), .AVG_LOG2(4)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .adcen     (adcen),
    .adcreqi   (adcreqi),
    .sample_i  (sample_i),
    .adcrdy    (adcrdy),
    .adcvalue  (adcvalue),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit at_tick();
    return (edge_n > 0) && (edge_n % CLK_DIV == 0);
  endfunction

  task automatic align_tick();
    int g = 0;
    do begin
      step();
      g++;
    end while (!at_tick() && g <= CLK_DIV);
    if (!at_tick()) check("align_tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int g = 0;
    while (seen < n && g < (n + 1) * CLK_DIV) begin
      step();
      g++;
      if (at_tick()) seen++;
    end
    if (seen < n) check("wait_ticks_timeout", seen, n);
  endtask

  // Raise adcreqi on a tick boundary, confirm busy after 1 clk, hold for n ticks, drop.
  task automatic req_pulse(input string tag, input int n);
    align_tick();
    adcreqi = 1'b1;
    step();
    check({tag, "_busy_1clk"}, adcrdy, 0);
    wait_ticks(n);
    adcreqi = 1'b0;
  endtask

  // Step until adcrdy is high or budget expires; optionally alternate sample_i each tick.
  task automatic wait_ready(input int budget, input bit alt,
                            output int n_clk, output int n_pulse, output int done_rdy);
    n_clk = 0;
    n_pulse = 0;
    done_rdy = 0;
    do begin
      step();
      n_clk++;
      if (conv_done) n_pulse++;
      if (alt && at_tick()) sample_i = (sample_i == '0) ? 14'h3FFF : 14'h0000;
    end while (!adcrdy && n_clk < budget);
    done_rdy = int'(conv_done);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_adcrdy", adcrdy, 0);
    check("rst_adcvalue", adcvalue, 0);
    check("rst_conv_done", conv_done, 0);
    step(); step();
    rst_i = 1'b0;

    // Disabled: stays OFF
    wait_ticks(3);
    check("off_while_disabled", adcrdy, 0);

    // Enable: READY on the next tick
    adcen = 1'b1;
    wait_ready(CLK_DIV + 5, 1'b0, clks, pulses, done_at_rdy);
    check("en_ready", adcrdy, 1);
    check("en_latency_le_div", int'(clks <= CLK_DIV), 1);

    // Nominal: 10-tick request, constant 1000
    sample_i = 14'd1000;
    req_pulse("nom", 10);
    wait_ready(CONV_CLKS + 40, 1'b0, clks, pulses, done_at_rdy);
    check("nom_conv_clks", clks, CONV_CLKS);
    check("nom_value", adcvalue, 1000);
    check("nom_pulses", pulses, 1);
    check("nom_done_with_rdy", done_at_rdy, 1);
    step();
    check("nom_done_one_clk", conv_done, 0);
    check("nom_rdy_holds", adcrdy, 1);

    // Averaging at the minimum accepted request length (4 ticks)
    sample_i = 14'h0000;
    req_pulse("avg", 4);
    wait_ready(CONV_CLKS + 40, 1'b1, clks, pulses, done_at_rdy);
    check("avg_conv_clks", clks, CONV_CLKS);
    check("avg_value", adcvalue, 14'h1FFF);
    check("avg_pulses", pulses, 1);

    // Glitch one tick short of the minimum
    sample_i = 14'd500;
    req_pulse("g3", 3);
    wait_ready(CONV_CLKS + 40, 1'b0, clks, pulses, done_at_rdy);
    check("g3_back_to_ready_clks", clks, 1);
    check("g3_value_kept", adcvalue, 14'h1FFF);
    check("g3_no_pulse", pulses + done_at_rdy, 0);

    // Glitch of 2 ticks
    req_pulse("g2", 2);
    wait_ready(CONV_CLKS + 40, 1'b0, clks, pulses, done_at_rdy);
    check("g2_back_to_ready_clks", clks, 1);
    check("g2_value_kept", adcvalue, 14'h1FFF);
    wait_ticks(18);
    check("g2_still_ready", adcrdy, 1);
    check("g2_value_after", adcvalue, 14'h1FFF);

    // Abort: adcen dropped at the 8th CONV tick
    req_pulse("abort", 6);
    wait_ticks(8);
    adcen = 1'b0;
    step();
    check("abort_off", adcrdy, 0);
    pulses = 0;
    for (int i = 0; i < CONV_CLKS; i++) begin
      step();
      if (conv_done || adcrdy) pulses++;
    end
    check("abort_no_pulse_no_rdy", pulses, 0);
    check("abort_value_kept", adcvalue, 14'h1FFF);
    adcen = 1'b1;
    wait_ready(CLK_DIV + 5, 1'b0, clks, pulses, done_at_rdy);
    check("abort_reenable_ready", adcrdy, 1);
    sample_i = 14'd1234;
    req_pulse("post_abort", 5);
    wait_ready(CONV_CLKS + 40, 1'b0, clks, pulses, done_at_rdy);
    check("post_abort_value", adcvalue, 1234);
    check("post_abort_pulses", pulses, 1);

    // Back-to-back: request re-raised during CONV and held
    sample_i = 14'd2000;
    req_pulse("b2b1", 4);
    wait_ticks(3);
    adcreqi = 1'b1;
    wait_ready(CONV_CLKS, 1'b0, clks, pulses, done_at_rdy);
    check("b2b1_conv_clks", clks, CONV_CLKS - 3 * CLK_DIV);
    check("b2b1_value", adcvalue, 2000);
    check("b2b1_pulses", pulses, 1);
    sample_i = 14'd3000;
    step();
    check("b2b_req_after_1clk", adcrdy, 0);
    wait_ticks(4);
    adcreqi = 1'b0;
    wait_ready(CONV_CLKS + 40, 1'b0, clks, pulses, done_at_rdy);
    check("b2b2_conv_clks", clks, CONV_CLKS);
    check("b2b2_value", adcvalue, 3000);
    check("b2b2_pulses", pulses, 1);

    // Reset in the middle of a conversion
    sample_i = 14'd100;
    req_pulse("rstconv", 4);
    wait_ticks(5);
    #2;
    rst_i = 1'b1;
    #1;
    check("rstconv_adcrdy", adcrdy, 0);
    check("rstconv_adcvalue", adcvalue, 0);
    step(); step();
    rst_i = 1'b0;
    wait_ready(CLK_DIV + 5, 1'b0, clks, pulses, done_at_rdy);
    check("rstconv_ready", adcrdy, 1);
    check("rstconv_latency_le_div", int'(clks <= CLK_DIV), 1);
    check("rstconv_no_pulse", pulses, 0);
    check("rstconv_value_zero", adcvalue, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_adc_responder
